// File: rtl/cdb_writeback.sv
// Purpose : CDB consumer. Buffers (tag, data) broadcasts, owns the register
//           status table (Qi) and writes matching registers one per cycle.
// Latency : push at edge t -> compares in cycles t+2..t+NREG+1, each write one
//           edge after its compare, retire pulse at edge t+NREG+2.
// Backpressure: cdb_ready_o = (count < FIFO_DEPTH), driven from count only, so
//           a full FIFO refuses a push even on a cycle when it pops.
// Ports   : clk_i/rst_ni (async active-low); cdb_* broadcast input;
//           disp_* rename updates; rf_* registered write port; qi_o flattened
//           status table; retire_* release pulse; fifo_count_o occupancy.
module cdb_writeback #(
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 16,
    parameter int NREG       = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = $clog2(NREG),
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cdb_valid_i,
    output logic                    cdb_ready_o,
    input  logic [TAG_W-1:0]        cdb_tag_i,
    input  logic [DATA_W-1:0]       cdb_data_i,
    input  logic                    disp_enable_i,
    input  logic [IDX_W-1:0]        disp_reg_i,
    input  logic [TAG_W-1:0]        disp_tag_i,
    output logic                    rf_we_o,
    output logic [IDX_W-1:0]        rf_addr_o,
    output logic [DATA_W-1:0]       rf_wdata_o,
    output logic [NREG*TAG_W-1:0]   qi_o,
    output logic                    retire_valid_o,
    output logic [TAG_W-1:0]        retire_tag_o,
    output logic [CNT_W-1:0]        fifo_count_o
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } bcast_t;

    // ST_ARM is the settle cycle between wake-up and the first compare.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [NREG-1:0][TAG_W-1:0]  qi_q, qi_d;
    logic                        rf_we_q, rf_we_d;
    logic [IDX_W-1:0]            rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]           rf_wdata_q, rf_wdata_d;
    logic                        retire_valid_q, retire_valid_d;
    logic [TAG_W-1:0]            retire_tag_q, retire_tag_d;

    bcast_t                      mem_q [FIFO_DEPTH];
    bcast_t                      head;

    logic push, pop, scanning, match, conflict, do_write;

    assign cdb_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
    // Tag 0 means "no producer"; such a broadcast is dropped outright.
    assign push        = cdb_valid_i && cdb_ready_o && (cdb_tag_i != '0);
    assign head        = mem_q[rd_ptr_q];
    assign scanning    = (state_q == ST_SCAN);
    assign pop         = scanning && (idx_q == IDX_W'(NREG - 1));
    // Head tag is never 0, so a valid (Qi=0) register can never match.
    assign match       = scanning && (qi_q[idx_q] == head.tag);
    // A rename on the register under compare makes the broadcast value stale.
    assign conflict    = disp_enable_i && (disp_reg_i == idx_q);
    assign do_write    = match && !conflict;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        qi_d           = qi_q;
        rf_we_d        = do_write;
        rf_addr_d      = rf_addr_q;
        rf_wdata_d     = rf_wdata_q;
        retire_valid_d = pop;
        retire_tag_d   = retire_tag_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            retire_tag_d = head.tag;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (do_write) begin
            qi_d[idx_q] = '0;
            rf_addr_d   = idx_q;
            rf_wdata_d  = head.data;
        end
        // Applied last so a rename always overrides a same-cycle clear.
        if (disp_enable_i) begin
            qi_d[disp_reg_i] = disp_tag_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_SCAN;
                idx_d   = '0;
            end
            ST_SCAN: begin
                if (pop) begin
                    idx_d = '0;
                    // A push on the pop edge keeps the scan going back-to-back.
                    if (count_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            qi_q           <= '0;
            rf_we_q        <= 1'b0;
            rf_addr_q      <= '0;
            rf_wdata_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_tag_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            qi_q           <= qi_d;
            rf_we_q        <= rf_we_d;
            rf_addr_q      <= rf_addr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_valid_q <= retire_valid_d;
            retire_tag_q   <= retire_tag_d;
        end
    end

    // Buffer storage needs no reset: entries are only read behind the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{tag: cdb_tag_i, data: cdb_data_i};
        end
    end

    assign rf_we_o        = rf_we_q;
    assign rf_addr_o      = rf_addr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign qi_o           = qi_q;
    assign retire_valid_o = retire_valid_q;
    assign retire_tag_o   = retire_tag_q;
    assign fifo_count_o   = count_q;

endmodule
